seg7_scan_driver: RTL and testbench

//  Output-side counterpart of the keypad encoder. The encoder scans keys into hex nibbles;

---
 rtl/seg7_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Two-digit time-multiplexed seven-segment driver with double-buffered display value.
// Optional leading-zero blanking of digit 1 when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
   parameter logic [23:0] REFRESH_DIV = 24'd10_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] value,
   input  logic       flag_in,
   input  logic       load,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] dig_sel,
   output logic       committed
);

   typedef enum logic {
      DIG0 = 1'b0,
      DIG1 = 1'b1
   } digit_t;

   digit_t      state;
   digit_t      state_next;
   logic [23:0] cnt;
   logic [23:0] cnt_next;
   logic        tick;
   logic        boundary;
   logic        commit;

   logic [7:0]  pend_reg;
   logic        pend_flag;
   logic        pend_valid;
   logic        pend_valid_next;

   logic [7:0]  disp_reg;
   logic        disp_flag;
   logic [7:0]  disp_next;
   logic        disp_flag_next;

   logic [6:0]  seg_next;
   logic        dp_next;
   logic [1:0]  dig_sel_next;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] digit_seg(input logic [7:0] disp, input digit_t d);
      logic [3:0] nib;
      nib = (d == DIG1) ? disp[7:4] : disp[3:0];
`ifdef SEG7_LZB_EN
      // Blank a leading zero but keep the scan slot so brightness stays uniform.
      if ((d == DIG1) && (nib == 4'h0)) begin
         return 7'h00;
      end
`endif
      return hex_to_seg(nib);
   endfunction

   // Prescaler and frame-boundary detection
   always_comb begin
      tick     = ena && (cnt == (REFRESH_DIV - 24'd1));
      boundary = tick && (state == DIG1);
      commit   = boundary && pend_valid;
      cnt_next = cnt;
      if (tick) begin
         cnt_next = 24'd0;
      end else if (ena) begin
         cnt_next = cnt + 24'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 24'd0;
      end else begin
         cnt <= cnt_next;
      end
   end

   // Digit-index FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DIG0;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (tick) begin
         case (state)
            DIG0:    state_next = DIG1;
            default: state_next = DIG0;
         endcase
      end
   end

   // Pending buffer: a load on the boundary cycle replaces the contents after they commit
   always_comb begin
      pend_valid_next = pend_valid;
      if (load) begin
         pend_valid_next = 1'b1;
      end else if (commit) begin
         pend_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
      end else begin
         pend_valid <= pend_valid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         pend_reg  <= value;
         pend_flag <= flag_in;
      end
   end

   // Display register and registered outputs
   always_comb begin
      disp_next      = disp_reg;
      disp_flag_next = disp_flag;
      if (commit) begin
         disp_next      = pend_reg;
         disp_flag_next = pend_flag;
      end
   end

   always_comb begin
      seg_next     = 7'h00;
      dp_next      = 1'b0;
      dig_sel_next = 2'b00;
      if (ena) begin
         seg_next     = digit_seg(disp_next, state_next);
         dp_next      = disp_flag_next && (state_next == DIG0);
         dig_sel_next = {state_next == DIG1, state_next == DIG0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_reg  <= 8'h00;
         disp_flag <= 1'b0;
         seg       <= 7'h00;
         dp        <= 1'b0;
         dig_sel   <= 2'b00;
         committed <= 1'b0;
      end else begin
         disp_reg  <= disp_next;
         disp_flag <= disp_flag_next;
         seg       <= seg_next;
         dp        <= dp_next;
         dig_sel   <= dig_sel_next;
         committed <= commit;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (REFRESH_DIV=4) against a frame-level model.
// Build with SEG7_LZB_EN defined to check the leading-zero blanking variant.
module tb_seg7_scan_driver;

   localparam int DIV = 4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] value;
   logic       flag_in;
   logic       load;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] dig_sel;
   logic       committed;

   seg7_scan_driver #(.REFRESH_DIV(24'd4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .value     (value),
      .flag_in   (flag_in),
      .load      (load),
      .seg       (seg),
      .dp        (dp),
      .dig_sel   (dig_sel),
      .committed (committed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state: hold position, shown digit, shown value, pending loads
   int m_cnt;
   int m_digit;
   int m_disp;
   int m_flag;
   int pend[$];
   int exp_seg;
   int exp_dp;
   int exp_dig;
   int exp_committed;

   logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_digit = 0;
      m_disp = 0;
      m_flag = 0;
      pend.delete();
      exp_seg = 0;
      exp_dp = 0;
      exp_dig = 0;
      exp_committed = 0;
   endtask

   task automatic model_update();
      int nib;
      exp_committed = 0;
      if (ena) begin
         if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            if (m_digit == 1 && pend.size() != 0) begin
               m_disp = pend[$] & 'hFF;
               m_flag = (pend[$] >> 8) & 1;
               pend.delete();
               exp_committed = 1;
            end
            m_digit = 1 - m_digit;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      if (load) pend.push_back({23'd0, flag_in, value});
      if (ena) begin
         nib = (m_digit == 1) ? (m_disp >> 4) : (m_disp & 15);
         exp_seg = int'(seg_tbl[nib]);
`ifdef SEG7_LZB_EN
         if (m_digit == 1 && nib == 0) exp_seg = 0;
`endif
         exp_dig = (m_digit == 1) ? 2 : 1;
         exp_dp = (m_flag == 1 && m_digit == 0) ? 1 : 0;
      end else begin
         exp_seg = 0;
         exp_dp = 0;
         exp_dig = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_update();
      #1;
      check("seg", {25'd0, seg}, exp_seg);
      check("dp", {31'd0, dp}, exp_dp);
      check("dig_sel", {30'd0, dig_sel}, exp_dig);
      check("committed", {31'd0, committed}, exp_committed);
   endtask

   task automatic do_load(input logic [7:0] v, input logic f);
      value = v;
      flag_in = f;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_commit(input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (committed !== 1'b1 && n < budget);
      check("commit_seen", {31'd0, committed}, 1);
   endtask

   task automatic sync_frame();
      int n = 0;
      while (!(m_digit == 0 && m_cnt == 0) && n < 20) begin
         step();
         n++;
      end
      check("frame_sync", (m_digit == 0 && m_cnt == 0) ? 1 : 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int c1;
      rst_n = 1'b0;
      ena = 1'b1;
      value = 8'h00;
      flag_in = 1'b0;
      load = 1'b0;
      model_reset();
      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();

      // Single load with flag
      do_load(8'h3A, 1'b1);
      wait_commit(20);
      check("t2_dig0_sel", {30'd0, dig_sel}, 2'b01);
      check("t2_dig0_seg", {25'd0, seg}, 7'h77);
      check("t2_dig0_dp", {31'd0, dp}, 1);
      repeat (4) step();
      check("t2_dig1_sel", {30'd0, dig_sel}, 2'b10);
      check("t2_dig1_seg", {25'd0, seg}, 7'h4F);
      check("t2_dig1_dp", {31'd0, dp}, 0);

      // Two loads inside one frame: last wins
      sync_frame();
      do_load(8'h12, 1'b0);
      step();
      do_load(8'h34, 1'b0);
      wait_commit(20);
      check("t3_dig0_seg", {25'd0, seg}, 7'h66);
      repeat (4) step();
      check("t3_dig1_seg", {25'd0, seg}, 7'h4F);
      n = 0;
      repeat (16) begin
         step();
         if (committed === 1'b1) n++;
      end
      check("t3_extra_commits", n, 0);

      // Enable low mid-digit
      sync_frame();
      repeat (2) step();
      ena = 1'b0;
      repeat (10) step();
      check("t4_blank_sel", {30'd0, dig_sel}, 0);
      ena = 1'b1;
      step();
      check("t4_resume_sel", {30'd0, dig_sel}, 2'b01);
      n = 0;
      while (dig_sel !== 2'b10 && n < 10) begin
         step();
         n++;
      end
      check("t4_hold_left", n, 1);

      // Load exactly on the boundary cycle
      sync_frame();
      do_load(8'h56, 1'b0);
      repeat (6) step();
      do_load(8'h78, 1'b0);
      check("t5_first_commit", {31'd0, committed}, 1);
      check("t5_first_seg", {25'd0, seg}, 7'h7D);
      c1 = cyc;
      wait_commit(20);
      check("t5_gap", cyc - c1, 8);
      check("t5_second_seg", {25'd0, seg}, 7'h7F);

      // Leading zero on digit 1
      do_load(8'h05, 1'b0);
      wait_commit(20);
      check("t6_dig0_seg", {25'd0, seg}, 7'h6D);
      repeat (4) step();
      check("t6_dig1_sel", {30'd0, dig_sel}, 2'b10);
`ifdef SEG7_LZB_EN
      check("t6_dig1_seg", {25'd0, seg}, 7'h00);
`else
      check("t6_dig1_seg", {25'd0, seg}, 7'h3F);
`endif

      // Random traffic
      repeat (400) begin
         ena = ($urandom_range(0, 9) != 0);
         load = ($urandom_range(0, 6) == 0);
         value = 8'($urandom);
         flag_in = 1'($urandom);
         step();
      end
      ena = 1'b1;
      load = 1'b0;

      // Asynchronous reset mid-frame with a pending load
      do_load(8'h3A, 1'b1);
      wait_commit(20);
      repeat (2) step();
      do_load(8'h99, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t1_seg", {25'd0, seg}, 0);
      check("t1_dp", {31'd0, dp}, 0);
      check("t1_dig_sel", {30'd0, dig_sel}, 0);
      check("t1_committed", {31'd0, committed}, 0);
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      n = 0;
      repeat (20) begin
         step();
         if (committed === 1'b1) n++;
      end
      check("t1_pend_lost", n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
